// File: rtl/jt89_wrbuf.sv
// ----------------------------------------------------------------------------
// jt89_wrbuf
// ----------------------------------------------------------------------------
// Write buffer and pacer in front of the jt89 PSG core. Single-cycle CPU write
// strobes are queued in a small FIFO. Each queued byte is replayed to the PSG
// as one clean low pulse on psg_wr_n, with psg_din held stable for the whole
// pulse and the gap after it. This guarantees that the PSG's falling-edge
// detector sees every write exactly once.
//
// Parameters:
//   AW    FIFO address width; the FIFO holds 2**AW bytes
//   HOLD  psg_wr_n low time, counted in clk_en ticks (>= 1)
//   GAP   psg_wr_n high time after each write, in clk_en ticks (>= 1)
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   clk_en     PSG clock enable; the HOLD/GAP timers only advance on it
//   cpu_we     write strobe, one byte per high clk cycle
//   cpu_din    CPU data byte
//   flush      discard every queued byte
//   ovf_clr    clear the sticky overflow flag (and the drop counter)
//   cpu_ready  high while the FIFO is not full
//   busy       high while bytes are queued or a write is in progress
//   level      FIFO occupancy, 0 .. 2**AW
//   ovf        sticky flag: a write was dropped because the FIFO was full
//   psg_wr_n   write strobe to jt89 (registered)
//   psg_din    data byte to jt89 (registered)
//   drop_cnt   count of dropped writes, saturating at 0xFF
//
// Build option:
//   JT89_WRBUF_DROPCNT_EN  when defined, drop_cnt is a live saturating
//                          counter. When undefined, drop_cnt is tied to 0x00
//                          and no counter logic exists.
// ----------------------------------------------------------------------------
module jt89_wrbuf #(
    parameter int AW   = 3,
    parameter int HOLD = 4,
    parameter int GAP  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_en,
    input  logic          cpu_we,
    input  logic [7:0]    cpu_din,
    input  logic          flush,
    input  logic          ovf_clr,
    output logic          cpu_ready,
    output logic          busy,
    output logic [AW:0]   level,
    output logic          ovf,
    output logic          psg_wr_n,
    output logic [7:0]    psg_din,
    output logic [7:0]    drop_cnt
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LVL_ONE  = (AW + 1)'(1);

    // The timer is reloaded with HOLD and then with GAP, so it must fit the
    // larger of the two.
    localparam int TMAX = (HOLD > GAP) ? HOLD : GAP;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] HOLD_T = TW'(HOLD);
    localparam logic [TW-1:0] GAP_T  = TW'(GAP);
    localparam logic [TW-1:0] ONE_T  = TW'(1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ASSERT  = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   level_q, level_d;
    logic [1:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          wr_n_q, wr_n_d;
    logic [7:0]    din_q, din_d;
    logic          ovf_q, ovf_d;

    logic full;
    logic empty;
    logic do_push;
    logic do_pop;
    logic do_drop;

    // FIFO bookkeeping. Fullness is judged on the level before the edge, so
    // a pop in the same cycle never makes room for a push. A flush wins over
    // everything: the pending push is discarded without counting as a drop,
    // and no new write is started from the queue being thrown away.
    always_comb begin
        full    = (level_q == FULL_LVL);
        empty   = (level_q == '0);
        do_pop  = (state_q == ST_IDLE) && !empty && !flush;
        do_push = cpu_we && !full && !flush;
        do_drop = cpu_we &&  full && !flush;

        wptr_d  = wptr_q + AW'(do_push);
        rptr_d  = flush ? wptr_q : (rptr_q + AW'(do_pop));

        level_d = level_q;
        if (flush) begin
            level_d = '0;
        end else if (do_push && !do_pop) begin
            level_d = level_q + LVL_ONE;
        end else if (do_pop && !do_push) begin
            level_d = level_q - LVL_ONE;
        end

        // A drop sets the flag even when a clear arrives on the same edge.
        ovf_d = ovf_q;
        if (do_drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Write pacer. IDLE starts a write on any clk edge when data is queued.
    // ASSERT and RELEASE only count on clk_en, which keeps the pulse width
    // tied to the PSG's own clock. A flush does not touch the pacer, so a
    // write that has already started always runs to completion.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        wr_n_d  = wr_n_q;
        din_d   = din_q;
        case (state_q)
            ST_IDLE: begin
                wr_n_d = 1'b1;
                if (do_pop) begin
                    din_d   = mem_q[rptr_q];
                    timer_d = HOLD_T;
                    wr_n_d  = 1'b0;
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (clk_en) begin
                    if (timer_q == ONE_T) begin
                        wr_n_d  = 1'b1;
                        timer_d = GAP_T;
                        state_d = ST_RELEASE;
                    end else begin
                        timer_d = timer_q - ONE_T;
                    end
                end
            end
            ST_RELEASE: begin
                if (clk_en) begin
                    if (timer_q == ONE_T) begin
                        state_d = ST_IDLE;
                    end else begin
                        timer_d = timer_q - ONE_T;
                    end
                end
            end
            default: begin
                wr_n_d  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            state_q <= ST_IDLE;
            timer_q <= '0;
            wr_n_q  <= 1'b1;
            din_q   <= 8'h00;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            state_q <= state_d;
            timer_q <= timer_d;
            wr_n_q  <= wr_n_d;
            din_q   <= din_d;
            ovf_q   <= ovf_d;
        end
    end

    // FIFO storage. It has no reset: the pointers define which entries are
    // valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= cpu_din;
        end
    end

`ifdef JT89_WRBUF_DROPCNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // Saturating drop counter. An increment on the same edge as a clear
    // restarts the count at 1.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (do_drop) begin
            if (ovf_clr) begin
                drop_cnt_d = 8'h01;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'h01;
            end
        end else if (ovf_clr) begin
            drop_cnt_d = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= 8'h00;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 8'h00;
`endif

    assign cpu_ready = (level_q != FULL_LVL);
    assign busy      = (level_q != '0) || (state_q != ST_IDLE);
    assign level     = level_q;
    assign ovf       = ovf_q;
    assign psg_wr_n  = wr_n_q;
    assign psg_din   = din_q;

endmodule

// File: doc/jt89_wrbuf.md
Name: jt89_wrbuf

Overview:
- Write buffer and pacer that sits directly upstream of the jt89 PSG core.
- Accepts single-cycle CPU write strobes into a small FIFO.
- Replays each byte to the PSG as a clean wr_n low pulse with a stable data byte, so the PSG's falling-edge detector sees every write exactly once.
- Drives a READY-style output and sets a sticky overflow flag when the FIFO is full.

Parameters:
- AW, 3, FIFO address width; depth = 2**AW entries.
- HOLD, 4, psg_wr_n low time in clk_en ticks; legal range ≥1.
- GAP, 2, psg_wr_n high time in clk_en ticks after each write; legal range ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- clk_en  in  1  PSG clock enable (same enable fed to jt89); HOLD/GAP timers advance only on it
- cpu_we  in  1  write strobe, one byte per high clk cycle
- cpu_din  in  8  CPU data byte
- flush  in  1  discard queued bytes
- ovf_clr  in  1  clear sticky overflow
- cpu_ready  out  1  high when FIFO not full
- busy  out  1  high when FIFO non-empty or FSM not IDLE
- level  out  AW+1  FIFO occupancy, 0..2**AW
- ovf  out  1  sticky: a write was dropped
- psg_wr_n  out  1  to jt89 wr_n
- psg_din  out  8  to jt89 din
- drop_cnt  out  8  dropped-write count (see Optional Feature)

Behaviour:
- Reset values:
  - psg_wr_n = 1, psg_din = 0x00, level = 0, ovf = 0, drop_cnt = 0, FSM in IDLE.
  - cpu_ready = 1, busy = 0.
  - FIFO pointers = 0; RAM contents undefined.
- Reset mid-write forces psg_wr_n = 1 on the next edge. No partial state survives.
- Push:
  - If cpu_we and level < 2**AW (value before the edge), write cpu_din at wptr, wptr++ (wraps mod 2**AW), level++.
  - If full, drop the byte and set ovf. A same-cycle pop does NOT free a slot for that push.
- Pop: only in IDLE when level ≠ 0. rptr++ (wraps), level--.
- Simultaneous push and pop: level unchanged.
- cpu_ready = (level ≠ 2**AW), combinational from the level register.
- FSM states:
  - IDLE, psg_wr_n = 1. If level ≠ 0 on any clk edge (independent of clk_en): load psg_din ← head, pop, load timer ← HOLD, go to ASSERT.
  - ASSERT, psg_wr_n = 0, psg_din held. On each clk_en, timer--. When timer reaches 1 on a clk_en edge: psg_wr_n ← 1, timer ← GAP, go to RELEASE.
  - RELEASE, psg_wr_n = 1, psg_din held. On each clk_en, timer--. When timer reaches 1 on a clk_en edge, go to IDLE.
- psg_wr_n is registered. psg_din changes only on the IDLE→ASSERT edge.
- Latency:
  - A push at edge N into an empty, idle buffer drives psg_wr_n low after edge N+1.
  - Minimum spacing between falling edges of psg_wr_n = HOLD + GAP clk_en ticks + 1 clk.
- clk_en held low stalls ASSERT/RELEASE indefinitely with outputs held.
- Flush:
  - Sets rptr ← wptr and level ← 0 on the same edge.
  - A write in ASSERT or RELEASE completes normally; it is never truncated.
  - A push in the same cycle as flush is discarded, and ovf is NOT set.
- ovf: set on drop, cleared by ovf_clr. If both occur on the same edge, set wins.
- busy = (level ≠ 0) | (state ≠ IDLE).

Optional Feature:
- Macro: JT89_WRBUF_DROPCNT_EN.
- Defined: drop_cnt increments on each dropped write and saturates at 0xFF. It is cleared by rst and by ovf_clr; an increment on the same edge as ovf_clr wins (result 1).
- Undefined: drop_cnt is tied to 0x00 and no counter logic is synthesised. All other behaviour is identical.

Test Plan:
- Reset with clk_en every 2nd clk, HOLD=4, GAP=2, then push 0x9F once → psg_wr_n falls 1 clk after the push edge, stays low 4 clk_en ticks (8 clk), then high ≥2 clk_en ticks. psg_din = 0x9F throughout. level returns to 0; busy drops after RELEASE.
- Push 0x80, 0x0A, 0xBF on back-to-back clks → the three bytes appear on psg_din in order, each framed by a distinct wr_n low pulse. A jt89 instance attached downstream ends with tone0 = 0x0A0 and vol1 = 0xF.
- Push 10 bytes back-to-back (AW=3) → the first byte pops after 1 clk, so 9 writes are accepted and 1 is dropped. cpu_ready is low while level = 8; ovf = 1; drop_cnt = 1 with the macro, 0 without. ovf_clr clears both.
- Flush while the second of four bytes is in ASSERT → that write completes its full HOLD, level → 0, and no further wr_n pulses occur.
- Assert rst during ASSERT → psg_wr_n = 1 on the next edge, level = 0. A following push of 0xE5 produces a normal pulse.
- Hold clk_en low for 50 clk while in ASSERT → psg_wr_n stays 0 and psg_din stays stable. The pulse resumes and completes once clk_en toggles.
